// File: rtl/mole_pkg.sv
// -----------------------------------------------------------------------------
// mole_pkg
// Shared definitions for the whack-a-mole playfield:
//   - default hole count and mole lifetime
//   - HOLE_W, the hole-index width for the default hole count
//   - LFSR_SEED, the reset value of the optional start-index LFSR
//   - state_t, the request-placement FSM state encoding
// -----------------------------------------------------------------------------
package mole_pkg;

    localparam int NUM_HOLES_DEF = 8;
    localparam int MOLE_LIFE_DEF = 3;
    localparam int HOLE_W        = $clog2(NUM_HOLES_DEF);

    localparam logic [7:0] LFSR_SEED = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        PICK,
        PROBE,
        PLACE,
        DROP
    } state_t;

endpackage

// File: rtl/mole_lfsr.sv
// -----------------------------------------------------------------------------
// mole_lfsr
// 8-bit Fibonacci LFSR (taps 8,6,5,4) that advances every cycle and supplies
// a pseudo-random starting hole for the placement search.
// Only instantiated by mole_field when MOLE_FIELD_LFSR_EN is defined.
//
// Ports:
//   clk        clock, rising edge
//   reset      synchronous, active-low; loads LFSR_SEED
//   start_idx  low OUT_W bits of the LFSR state
// -----------------------------------------------------------------------------
module mole_lfsr
    import mole_pkg::*;
#(
    parameter int OUT_W = HOLE_W
) (
    input  logic             clk,
    input  logic             reset,
    output logic [OUT_W-1:0] start_idx
);

    logic [7:0] lfsr_reg;
    logic       feedback;

    // Taps 8,6,5,4 in 1-based numbering map to bits 7,5,4,3.
    assign feedback = lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3];

    always_ff @(posedge clk) begin
        if (!reset) begin
            lfsr_reg <= LFSR_SEED;
        end else begin
            lfsr_reg <= {lfsr_reg[6:0], feedback};
        end
    end

    assign start_idx = lfsr_reg[OUT_W-1:0];

endmodule

// File: rtl/mole_field.sv
// -----------------------------------------------------------------------------
// mole_field
// Whack-a-mole playfield. Rising edges on request_mole ask for a mole; an FSM
// searches for a free hole starting from a start index and raises a mole there
// (request_ack) or discards the request when every hole is full (request_drop).
// Each raised mole lives MOLE_LIFE one_hz_enable ticks; player hits clear it
// and bump a saturating 8-bit score.
//
// Build option:
//   MOLE_FIELD_LFSR_EN  defined   -> start index from an 8-bit LFSR (mole_lfsr)
//                       undefined -> start index from a round-robin pointer
//
// Ports:
//   clk            clock, rising edge
//   reset          synchronous, active-low
//   one_hz_enable  lifetime tick strobe
//   request_mole   mole request level; each 0->1 edge is one request
//   hit_valid      player hit strobe
//   hit_hole       hole index of the hit
//   request_ack    one-cycle pulse: requested mole raised
//   request_drop   one-cycle pulse: request discarded, all holes occupied
//   moles_up       bit i high while hole i holds a mole
//   hit_pulse      hit on a raised mole
//   miss_pulse     at least one mole expired
//   whiff_pulse    hit on an empty hole
//   score          saturating count of successful hits
// -----------------------------------------------------------------------------
module mole_field
    import mole_pkg::*;
#(
    parameter int NUM_HOLES = NUM_HOLES_DEF,
    parameter int MOLE_LIFE = MOLE_LIFE_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         one_hz_enable,
    input  logic                         request_mole,
    input  logic                         hit_valid,
    input  logic [$clog2(NUM_HOLES)-1:0] hit_hole,
    output logic                         request_ack,
    output logic                         request_drop,
    output logic [NUM_HOLES-1:0]         moles_up,
    output logic                         hit_pulse,
    output logic                         miss_pulse,
    output logic                         whiff_pulse,
    output logic [7:0]                   score
);

    localparam int HW = $clog2(NUM_HOLES);

    state_t          state_reg;
    logic            req_sync_reg;
    logic            req_prev_reg;
    logic            pending_reg;
    logic [HW-1:0]   probe_idx_reg;
    logic [HW:0]     probe_cnt_reg;
    logic [HW-1:0]   start_idx;
    logic            ack_reg;
    logic            drop_reg;
    logic            hit_pulse_reg;
    logic            miss_pulse_reg;
    logic            whiff_pulse_reg;
    logic [7:0]      score_reg;

    logic [NUM_HOLES-1:0] moles_up_vec;
    logic [NUM_HOLES-1:0] hit_vec;
    logic [NUM_HOLES-1:0] expire_vec;
    logic [NUM_HOLES-1:0] place_vec;
    logic                 req_edge;

    assign req_edge = req_sync_reg & ~req_prev_reg;

`ifdef MOLE_FIELD_LFSR_EN
    mole_lfsr #(
        .OUT_W (HW)
    ) u_lfsr (
        .clk       (clk),
        .reset     (reset),
        .start_idx (start_idx)
    );
`else
    logic [HW-1:0] rr_ptr_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr_reg <= '0;
        end else if (state_reg == PLACE) begin
            rr_ptr_reg <= rr_ptr_reg + 1'b1;   // power-of-two hole count wraps naturally
        end
    end

    assign start_idx = rr_ptr_reg;
`endif

    // Per-hole state: presence flag plus life counter.
    // Priority: place (hole is free, so nothing else can apply), then hit,
    // then tick. A hit therefore beats an expiry on the same hole, and a
    // freshly placed hole ignores a tick in its placement cycle.
    for (genvar gi = 0; gi < NUM_HOLES; gi++) begin : g_hole
        logic       up_reg;
        logic [3:0] life_reg;

        assign hit_vec[gi]    = hit_valid && (hit_hole == HW'(gi)) && up_reg;
        assign place_vec[gi]  = (state_reg == PLACE) && (probe_idx_reg == HW'(gi));
        assign expire_vec[gi] = up_reg && one_hz_enable && (life_reg == 4'd1) && !hit_vec[gi];

        always_ff @(posedge clk) begin
            if (!reset) begin
                up_reg   <= 1'b0;
                life_reg <= 4'd0;
            end else if (place_vec[gi]) begin
                up_reg   <= 1'b1;
                life_reg <= 4'(MOLE_LIFE);
            end else if (hit_vec[gi]) begin
                up_reg   <= 1'b0;
                life_reg <= 4'd0;
            end else if (up_reg && one_hz_enable) begin
                life_reg <= life_reg - 4'd1;
                if (life_reg == 4'd1) begin
                    up_reg <= 1'b0;
                end
            end
        end

        assign moles_up_vec[gi] = up_reg;
    end

    // Request edge detection and placement FSM.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= IDLE;
            req_sync_reg  <= 1'b0;
            req_prev_reg  <= 1'b0;
            pending_reg   <= 1'b0;
            probe_idx_reg <= '0;
            probe_cnt_reg <= '0;
            ack_reg       <= 1'b0;
            drop_reg      <= 1'b0;
        end else begin
            req_sync_reg <= request_mole;
            req_prev_reg <= req_sync_reg;
            ack_reg      <= 1'b0;
            drop_reg     <= 1'b0;

            // A new edge takes precedence over the clear so a request that
            // arrives exactly as IDLE is left is not lost.
            if (req_edge) begin
                pending_reg <= 1'b1;
            end else if (state_reg == IDLE && pending_reg) begin
                pending_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (pending_reg) begin
                        state_reg <= PICK;
                    end
                end
                PICK: begin
                    probe_idx_reg <= start_idx;
                    probe_cnt_reg <= '0;
                    state_reg     <= PROBE;
                end
                PROBE: begin
                    // Sees pre-hit occupancy; a hole hit this cycle is free next cycle.
                    if (!moles_up_vec[probe_idx_reg]) begin
                        state_reg <= PLACE;
                        ack_reg   <= 1'b1;
                    end else begin
                        probe_idx_reg <= probe_idx_reg + 1'b1;
                        probe_cnt_reg <= probe_cnt_reg + 1'b1;
                        if (probe_cnt_reg == (HW+1)'(NUM_HOLES - 1)) begin
                            state_reg <= DROP;
                            drop_reg  <= 1'b1;
                        end
                    end
                end
                PLACE:   state_reg <= IDLE;
                DROP:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Registered event pulses and saturating score.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hit_pulse_reg   <= 1'b0;
            miss_pulse_reg  <= 1'b0;
            whiff_pulse_reg <= 1'b0;
            score_reg       <= 8'd0;
        end else begin
            hit_pulse_reg   <= |hit_vec;
            miss_pulse_reg  <= |expire_vec;
            whiff_pulse_reg <= hit_valid && !moles_up_vec[hit_hole];
            if ((|hit_vec) && (score_reg != 8'hFF)) begin
                score_reg <= score_reg + 8'd1;
            end
        end
    end

    assign request_ack  = ack_reg;
    assign request_drop = drop_reg;
    assign moles_up     = moles_up_vec;
    assign hit_pulse    = hit_pulse_reg;
    assign miss_pulse   = miss_pulse_reg;
    assign whiff_pulse  = whiff_pulse_reg;
    assign score        = score_reg;

endmodule

// File: tb/tb_mole_field.sv
// -----------------------------------------------------------------------------
// tb_mole_field
// Directed-vector bench for mole_field (default build: round-robin start,
// NUM_HOLES=8, MOLE_LIFE=3). One task per scenario; each task compares the
// DUT outputs against hand-computed values.
// -----------------------------------------------------------------------------
module tb_mole_field;

    logic       clk = 1'b0;
    logic       reset;
    logic       one_hz_enable;
    logic       request_mole;
    logic       hit_valid;
    logic [2:0] hit_hole;
    logic       request_ack;
    logic       request_drop;
    logic [7:0] moles_up;
    logic       hit_pulse;
    logic       miss_pulse;
    logic       whiff_pulse;
    logic [7:0] score;

    int checks   = 0;
    int failures = 0;

    mole_field dut (
        .clk           (clk),
        .reset         (reset),
        .one_hz_enable (one_hz_enable),
        .request_mole  (request_mole),
        .hit_valid     (hit_valid),
        .hit_hole      (hit_hole),
        .request_ack   (request_ack),
        .request_drop  (request_drop),
        .moles_up      (moles_up),
        .hit_pulse     (hit_pulse),
        .miss_pulse    (miss_pulse),
        .whiff_pulse   (whiff_pulse),
        .score         (score)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset         = 1'b0;
        request_mole  = 1'b0;
        hit_valid     = 1'b0;
        hit_hole      = 3'd0;
        one_hz_enable = 1'b0;
        step;
        step;
        reset = 1'b1;
        step;
    endtask

    // Issue one request edge and wait (bounded) for ack or drop.
    // lat counts clock edges after the edge that registers request_mole.
    task automatic do_request(output bit acked, output bit dropped, output int lat);
        acked   = 1'b0;
        dropped = 1'b0;
        lat     = -1;
        request_mole = 1'b1;
        step;
        request_mole = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step;
            if (request_ack) begin
                acked = 1'b1;
                lat   = i;
                break;
            end
            if (request_drop) begin
                dropped = 1'b1;
                lat     = i;
                break;
            end
        end
        step;   // let PLACE / DROP complete
    endtask

    task automatic tick;
        one_hz_enable = 1'b1;
        step;
        one_hz_enable = 1'b0;
    endtask

    task automatic hit(input logic [2:0] hole);
        hit_valid = 1'b1;
        hit_hole  = hole;
        step;
        hit_valid = 1'b0;
    endtask

    task automatic test_reset;
        logic [4:0] pulses;
        do_reset;
        pulses = {request_ack, request_drop, hit_pulse, miss_pulse, whiff_pulse};
        checks++;
        if (moles_up !== 8'h00) begin
            failures++;
            $display("FAIL reset_moles_up: got %h expected 00", moles_up);
        end
        checks++;
        if (score !== 8'd0) begin
            failures++;
            $display("FAIL reset_score: got %0d expected 0", score);
        end
        checks++;
        if (pulses !== 5'b0) begin
            failures++;
            $display("FAIL reset_pulses: got %b expected 00000", pulses);
        end
        $display("reset: moles_up=%h score=%0d pulses=%b", moles_up, score, pulses);
    endtask

    task automatic test_latency;
        bit acked, dropped;
        int lat;
        do_request(acked, dropped, lat);
        checks++;
        if (!acked || lat != 4) begin
            failures++;
            $display("FAIL first_ack_latency: got acked=%0d lat=%0d expected acked=1 lat=4", acked, lat);
        end
        checks++;
        if (request_ack !== 1'b0) begin
            failures++;
            $display("FAIL ack_one_cycle: got %b expected 0", request_ack);
        end
        checks++;
        if (moles_up !== 8'h01) begin
            failures++;
            $display("FAIL first_place: got %h expected 01", moles_up);
        end
        $display("request 1: acked=%0d lat=%0d moles_up=%h", acked, lat, moles_up);
        do_request(acked, dropped, lat);
        checks++;
        if (!acked || moles_up !== 8'h03) begin
            failures++;
            $display("FAIL second_place: got acked=%0d moles_up=%h expected 1 03", acked, moles_up);
        end
        $display("request 2: acked=%0d moles_up=%h", acked, moles_up);
    endtask

    task automatic test_occupancy;
        bit acked, dropped;
        int lat;
        logic [7:0] exp_up;
        exp_up = 8'h03;
        for (int i = 2; i < 8; i++) begin
            do_request(acked, dropped, lat);
            exp_up[i] = 1'b1;
            checks++;
            if (!acked || dropped || moles_up !== exp_up) begin
                failures++;
                $display("FAIL fill_hole%0d: got acked=%0d dropped=%0d moles_up=%h expected 1 0 %h",
                         i, acked, dropped, moles_up, exp_up);
            end
            $display("fill %0d: acked=%0d moles_up=%h", i, acked, moles_up);
        end
        do_request(acked, dropped, lat);
        checks++;
        if (!dropped || acked) begin
            failures++;
            $display("FAIL full_drop: got dropped=%0d acked=%0d expected 1 0", dropped, acked);
        end
        checks++;
        if (moles_up !== 8'hFF) begin
            failures++;
            $display("FAIL full_moles_up: got %h expected ff", moles_up);
        end
        checks++;
        if (request_drop !== 1'b0) begin
            failures++;
            $display("FAIL drop_one_cycle: got %b expected 0", request_drop);
        end
        $display("request 9: dropped=%0d acked=%0d lat=%0d moles_up=%h", dropped, acked, lat, moles_up);
    endtask

    task automatic test_lifetime;
        bit acked, dropped;
        int lat;
        do_reset;
        do_request(acked, dropped, lat);
        checks++;
        if (moles_up !== 8'h01) begin
            failures++;
            $display("FAIL life_raise: got %h expected 01", moles_up);
        end
        tick;
        tick;
        checks++;
        if (moles_up !== 8'h01 || miss_pulse !== 1'b0) begin
            failures++;
            $display("FAIL life_tick2: got moles_up=%h miss=%b expected 01 0", moles_up, miss_pulse);
        end
        tick;
        checks++;
        if (moles_up !== 8'h00 || miss_pulse !== 1'b1) begin
            failures++;
            $display("FAIL life_tick3: got moles_up=%h miss=%b expected 00 1", moles_up, miss_pulse);
        end
        step;
        checks++;
        if (miss_pulse !== 1'b0) begin
            failures++;
            $display("FAIL miss_one_cycle: got %b expected 0", miss_pulse);
        end
        $display("lifetime: moles_up=%h miss=%b", moles_up, miss_pulse);
    endtask

    task automatic test_multi_expire;
        bit acked, dropped;
        int lat;
        int miss_count;
        do_reset;
        do_request(acked, dropped, lat);
        do_request(acked, dropped, lat);
        tick;
        tick;
        miss_count = 0;
        tick;
        if (miss_pulse) miss_count++;
        for (int i = 0; i < 3; i++) begin
            step;
            if (miss_pulse) miss_count++;
        end
        checks++;
        if (miss_count != 1 || moles_up !== 8'h00) begin
            failures++;
            $display("FAIL multi_expire: got misses=%0d moles_up=%h expected 1 00", miss_count, moles_up);
        end
        $display("multi expire: misses=%0d moles_up=%h", miss_count, moles_up);
    endtask

    task automatic test_hits;
        bit acked, dropped;
        int lat;
        do_reset;
        do_request(acked, dropped, lat);   // hole 0
        hit(3'd0);
        checks++;
        if (hit_pulse !== 1'b1 || whiff_pulse !== 1'b0 || score !== 8'd1 || moles_up !== 8'h00) begin
            failures++;
            $display("FAIL hit_raised: got hit=%b whiff=%b score=%0d moles_up=%h expected 1 0 1 00",
                     hit_pulse, whiff_pulse, score, moles_up);
        end
        $display("hit hole0: hit=%b score=%0d moles_up=%h", hit_pulse, score, moles_up);
        hit(3'd5);
        checks++;
        if (whiff_pulse !== 1'b1 || hit_pulse !== 1'b0 || score !== 8'd1) begin
            failures++;
            $display("FAIL whiff_empty: got whiff=%b hit=%b score=%0d expected 1 0 1",
                     whiff_pulse, hit_pulse, score);
        end
        $display("hit hole5: whiff=%b score=%0d", whiff_pulse, score);
    endtask

    task automatic test_collision;
        bit acked, dropped;
        int lat;
        do_request(acked, dropped, lat);   // hole 1 (pointer advanced past 0)
        checks++;
        if (moles_up !== 8'h02) begin
            failures++;
            $display("FAIL collide_raise: got %h expected 02", moles_up);
        end
        tick;
        tick;
        one_hz_enable = 1'b1;
        hit(3'd1);
        one_hz_enable = 1'b0;
        checks++;
        if (hit_pulse !== 1'b1 || miss_pulse !== 1'b0 || score !== 8'd2 || moles_up !== 8'h00) begin
            failures++;
            $display("FAIL collision: got hit=%b miss=%b score=%0d moles_up=%h expected 1 0 2 00",
                     hit_pulse, miss_pulse, score, moles_up);
        end
        $display("collision: hit=%b miss=%b score=%0d", hit_pulse, miss_pulse, score);
    endtask

    task automatic test_saturation;
        bit acked, dropped;
        int lat;
        int hits_seen;
        do_reset;
        hits_seen = 0;
        for (int i = 0; i < 300; i++) begin
            do_request(acked, dropped, lat);
            hit(3'(i % 8));
            if (hit_pulse) hits_seen++;
        end
        checks++;
        if (score !== 8'd255) begin
            failures++;
            $display("FAIL score_saturate: got %0d expected 255", score);
        end
        checks++;
        if (hits_seen != 300) begin
            failures++;
            $display("FAIL hits_seen: got %0d expected 300", hits_seen);
        end
        $display("saturation: score=%0d hits=%0d", score, hits_seen);
    endtask

    task automatic test_reset_mid_probe;
        bit acked, dropped;
        int lat;
        int seen;
        do_reset;
        do_request(acked, dropped, lat);   // hole 0
        do_request(acked, dropped, lat);   // hole 1
        hit(3'd0);                          // score 1, moles_up 02
        request_mole = 1'b1;
        step;                               // edge registered
        request_mole = 1'b0;
        step;                               // pending set
        step;                               // PICK
        step;                               // PROBE
        reset = 1'b0;
        step;
        reset = 1'b1;
        checks++;
        if (moles_up !== 8'h00 || score !== 8'd0 ||
            {request_ack, request_drop, hit_pulse, miss_pulse, whiff_pulse} !== 5'b0) begin
            failures++;
            $display("FAIL midprobe_reset: got moles_up=%h score=%0d ack=%b drop=%b expected 00 0 0 0",
                     moles_up, score, request_ack, request_drop);
        end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step;
            if (request_ack || request_drop) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL midprobe_abandon: got %0d ack/drop pulses expected 0", seen);
        end
        do_request(acked, dropped, lat);
        checks++;
        if (!acked || moles_up !== 8'h01) begin
            failures++;
            $display("FAIL after_reset_req: got acked=%0d moles_up=%h expected 1 01", acked, moles_up);
        end
        $display("mid-probe reset: stray pulses=%0d next moles_up=%h", seen, moles_up);
    endtask

    initial begin
        reset         = 1'b0;
        request_mole  = 1'b0;
        hit_valid     = 1'b0;
        hit_hole      = 3'd0;
        one_hz_enable = 1'b0;
        test_reset;
        test_latency;
        test_occupancy;
        test_lifetime;
        test_multi_expire;
        test_hits;
        test_collision;
        test_saturation;
        test_reset_mid_probe;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mole_field.md
MOLE_FIELD -- requirements
Module: mole_field

Interface
REQ-001 Parameter NUM_HOLES, default 8, number of mole holes (power of two, 2..16).
REQ-002 Parameter MOLE_LIFE, default 3, lifetime of a raised mole in one_hz_enable ticks (1..15).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  reset is synchronous and active-low.
REQ-005 one_hz_enable  input  1  one-cycle tick strobe for mole lifetime.
REQ-006 request_mole  input  1  mole request from the mole music tracker; a rising edge is one request.
REQ-007 hit_valid  input  1  player hit strobe, one cycle.
REQ-008 hit_hole  input  clog2(NUM_HOLES)  hole index of the hit; qualified by hit_valid.
REQ-009 request_ack  output  1  one-cycle pulse when a requested mole is raised.
REQ-010 request_drop  output  1  one-cycle pulse when a request is discarded because all holes are occupied.
REQ-011 moles_up  output  NUM_HOLES  bit i high while hole i holds a mole.
REQ-012 hit_pulse / miss_pulse / whiff_pulse  output  1 each  hit on a raised mole / mole expired / hit on an empty hole.
REQ-013 score  output  8  count of successful hits.

Function
REQ-014 Request detection: a 0->1 transition of registered request_mole sets a one-deep pending flag; a further edge while pending is already set is lost, with no pulse.
REQ-015 FSM states: IDLE, PICK, PROBE, PLACE, DROP.
REQ-016 IDLE->PICK when pending=1; pending clears on leaving IDLE.
REQ-017 PICK loads the probe index from the start-index source (REQ-030/031) and zeros the probe count; PICK->PROBE.
REQ-018 PROBE, one hole per cycle: free hole -> PLACE; occupied hole -> index+1 modulo NUM_HOLES and count+1; count reaching NUM_HOLES -> DROP.
REQ-019 PLACE sets moles_up[index], loads that hole's life counter with MOLE_LIFE, pulses request_ack, then goes to IDLE.
REQ-020 DROP pulses request_drop, then goes to IDLE.
REQ-021 Best-case latency: request edge registered at cycle N; request_ack at N+4 (IDLE, PICK, PROBE, PLACE).
REQ-022 Each raised hole's life counter decrements on one_hz_enable; on 1->0 the hole clears and miss_pulse fires the same cycle.
REQ-023 A tick arriving in the same cycle as PLACE does not decrement the newly placed hole.
REQ-024 hit_valid on a raised hole clears it, pulses hit_pulse and increments score, saturating at 255.
REQ-025 hit_valid on an empty hole pulses whiff_pulse only.
REQ-026 Hit and expiry on the same hole in the same cycle: the hit wins; hit_pulse fires and miss_pulse does not.
REQ-027 Hit on the hole PROBE is examining in that same cycle: PROBE sees the pre-hit state and the hole becomes free next cycle.
REQ-028 Several holes expiring on one tick produce a single miss_pulse.

Reset
REQ-029 reset=0 at a clock edge sets FSM to IDLE, pending=0, moles_up=0, all life counters=0, score=0, all pulses=0, and round-robin pointer=0; with MOLE_FIELD_LFSR_EN defined, the LFSR seed is 8'hA5. Reset mid-operation abandons any request in flight, with no ack or drop.

Configuration
REQ-030 With MOLE_FIELD_LFSR_EN defined, the start index is the low clog2(NUM_HOLES) bits of an 8-bit Fibonacci LFSR (taps 8,6,5,4) that advances every cycle.
REQ-031 Without MOLE_FIELD_LFSR_EN, the start index is a round-robin pointer that advances by 1 modulo NUM_HOLES after each PLACE.

Structure
REQ-032 Package mole_pkg holds the FSM state enum, the defaults for NUM_HOLES and MOLE_LIFE, HOLE_W=clog2(NUM_HOLES), and the LFSR seed constant.
REQ-033 The LFSR is a separate sub-module, mole_lfsr; it is instantiated only when MOLE_FIELD_LFSR_EN is defined.

Verification
REQ-034 Without MOLE_FIELD_LFSR_EN: after reset, a request edge at cycle 10 -> request_ack at cycle 14 and moles_up=8'h01; a second request -> moles_up=8'h03.
REQ-035 Occupancy: fill all 8 holes, then send a 9th request -> request_drop pulse, no ack, and moles_up stays 8'hFF.
REQ-036 Lifetime: raise one mole with MOLE_LIFE=3 -> hole clears with miss_pulse on the 3rd subsequent one_hz_enable; the 2nd tick leaves it up.
REQ-037 Hits: hit_hole on a raised mole -> hit_pulse, score+1, bit cleared; hit on an empty hole -> whiff_pulse and score unchanged; 300 valid hits -> score=255.
REQ-038 Collision: hit_valid and the expiring tick on the same hole in the same cycle -> hit_pulse=1, miss_pulse=0, score+1.
REQ-039 Reset mid-PROBE: reset=0 held one cycle -> all outputs zero, and neither request_ack nor request_drop ever fires for that request.
